vga_line_fetch: RTL and testbench

- Parametrised scanline fetch engine; next generation of the fixed 8bpp VGA master fetch path.
- On each line request it reads one framebuffer row over Wishbone (classic, single-beat) and unpacks words into pixels in 1/2/4/8bpp palette modes or 24bpp direct mode.
- Applies optional 2x horizontal and vertical scaling and writes 24-bit RGB into a line buffer write port.
- Sits between the VGA register file (config inputs) and the scanline buffer; everything is in the system clock domain.

---
 rtl/vga_pkg.sv | 43 ++++
 rtl/vga_pixel_unpack.sv | 54 +++++
 rtl/vga_line_fetch.sv | 226 ++++++++++++++++++++++
 tb/tb_vga_line_fetch.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared encodings and helpers for the scanline fetch engine.
// Pure definitions; no timing or flow-control behaviour of its own.
package vga_pkg;

  localparam logic [2:0] MODE_1BPP   = 3'd0;
  localparam logic [2:0] MODE_2BPP   = 3'd1;
  localparam logic [2:0] MODE_4BPP   = 3'd2;
  localparam logic [2:0] MODE_8BPP   = 3'd3;
  localparam logic [2:0] MODE_DIRECT = 3'd4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    UNPACK = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Direct mode consumes the whole word as a single pixel.
  function automatic logic [5:0] bpp_of(input logic [2:0] mode);
    case (mode)
      MODE_1BPP:   bpp_of = 6'd1;
      MODE_2BPP:   bpp_of = 6'd2;
      MODE_4BPP:   bpp_of = 6'd4;
      MODE_DIRECT: bpp_of = 6'd32;
      default:     bpp_of = 6'd8;
    endcase
  endfunction

  function automatic logic [5:0] ppw_of(input logic [2:0] mode);
    case (mode)
      MODE_1BPP:   ppw_of = 6'd32;
      MODE_2BPP:   ppw_of = 6'd16;
      MODE_4BPP:   ppw_of = 6'd8;
      MODE_DIRECT: ppw_of = 6'd1;
      default:     ppw_of = 6'd4;
    endcase
  endfunction

  function automatic logic [2:0] norm_mode(input logic [2:0] mode);
    norm_mode = (mode > MODE_DIRECT) ? MODE_8BPP : mode;
  endfunction

endpackage

// File: rtl/vga_pixel_unpack.sv
// Word shift register yielding one MSB-first pixel field per advance; load wins over advance.
// Field output is combinational from the register; no backpressure, caller paces via adv_i.
module vga_pixel_unpack
  import vga_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [2:0]  mode_i,
  input  logic        load_i,
  input  logic [31:0] load_dat_i,
  input  logic [5:0]  load_cnt_i,
  input  logic        adv_i,
  output logic [23:0] field_o,
  output logic        last_o
);

  logic [31:0] shreg_q, shreg_d;
  logic [5:0]  cnt_q, cnt_d;

  always_comb begin
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    if (load_i) begin
      shreg_d = load_dat_i;
      cnt_d   = load_cnt_i;
    end else if (adv_i && (cnt_q != 6'd0)) begin
      shreg_d = shreg_q << bpp_of(mode_i);
      cnt_d   = cnt_q - 6'd1;
    end
  end

  always_comb begin
    case (mode_i)
      MODE_1BPP:   field_o = {23'd0, shreg_q[31]};
      MODE_2BPP:   field_o = {22'd0, shreg_q[31:30]};
      MODE_4BPP:   field_o = {20'd0, shreg_q[31:28]};
      MODE_DIRECT: field_o = shreg_q[23:0];
      default:     field_o = {16'd0, shreg_q[31:24]};
    endcase
  end

  assign last_o = (cnt_q == 6'd1);

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      shreg_q <= 32'd0;
      cnt_q   <= 6'd0;
    end else begin
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/vga_line_fetch.sv
// Scanline fetch: Wishbone single-beat row reads, unpack/palette/scale, line buffer writes.
// Write lands one cycle after the palette address issue; bus stalls simply hold the FSM in FETCH.
module vga_line_fetch
  import vga_pkg::*;
#(
  parameter int H_PIXELS = 640,
  parameter int Y_W      = 10,
  parameter int LB_AW    = 10,
  parameter int PAL_AW   = 8
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              line_start_i,
  input  logic [Y_W-1:0]    line_num_i,
  input  logic [31:0]       base_i,
  input  logic [15:0]       stride_i,
  input  logic [2:0]        mode_i,
  input  logic              hscale_i,
  input  logic              vscale_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              overrun_o,
  output logic              err_o,
  output logic [31:0]       wb_adr_o,
  output logic              wb_cyc_o,
  output logic              wb_stb_o,
  output logic              wb_we_o,
  output logic [3:0]        wb_sel_o,
  input  logic [31:0]       wb_dat_i,
  input  logic              wb_ack_i,
  input  logic              wb_err_i,
  output logic [PAL_AW-1:0] pal_adr_o,
  input  logic [23:0]       pal_dat_i,
  output logic              lb_we_o,
  output logic [LB_AW-1:0]  lb_adr_o,
  output logic [23:0]       lb_dat_o
);

  localparam int SL_W = $clog2(H_PIXELS + 1);
  localparam int WI_W = LB_AW + 1;

  state_t            state_q, state_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              ovr_q, ovr_d;
  logic              err_q, err_d;
  logic              cyc_q, cyc_d;
  logic [31:0]       adr_q, adr_d;
  logic [2:0]        mode_q, mode_d;
  logic              hs_q, hs_d;
  logic              phase_q, phase_d;
  logic [SL_W-1:0]   src_left_q, src_left_d;
  logic [WI_W-1:0]   wr_idx_q, wr_idx_d;
  logic              lb_we_q, lb_we_d;
  logic [LB_AW-1:0]  lb_adr_q, lb_adr_d;
  logic [23:0]       dir_q, dir_d;

  logic [Y_W-1:0]    row_sel;
  logic [31:0]       row_addr;
  logic [SL_W-1:0]   ppw_ext;
  logic [SL_W-1:0]   word_pix;
  logic              u_load, u_adv, issue;
  logic [23:0]       u_field;
  logic              u_last;
  logic              dir_mode;

  assign row_sel  = vscale_i ? (line_num_i >> 1) : line_num_i;
  assign row_addr = base_i + 32'(row_sel) * 32'(stride_i);
  assign dir_mode = (mode_q == MODE_DIRECT);

  // Final word of a row may carry fewer live pixels than the word holds.
  assign ppw_ext  = SL_W'(ppw_of(mode_q));
  assign word_pix = (src_left_q < ppw_ext) ? src_left_q : ppw_ext;

  vga_pixel_unpack u_unpack (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .mode_i     (mode_q),
    .load_i     (u_load),
    .load_dat_i (wb_dat_i),
    .load_cnt_i (6'(word_pix)),
    .adv_i      (u_adv),
    .field_o    (u_field),
    .last_o     (u_last)
  );

  always_comb begin
    state_d    = state_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    ovr_d      = ovr_q;
    err_d      = err_q;
    cyc_d      = cyc_q;
    adr_d      = adr_q;
    mode_d     = mode_q;
    hs_d       = hs_q;
    phase_d    = phase_q;
    src_left_d = src_left_q;
    wr_idx_d   = wr_idx_q;
    lb_we_d    = 1'b0;
    lb_adr_d   = lb_adr_q;
    dir_d      = dir_q;
    u_load     = 1'b0;
    u_adv      = 1'b0;
    issue      = 1'b0;

    if (line_start_i && (state_q != IDLE)) begin
      ovr_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (line_start_i) begin
          if (done_q) begin
            ovr_d = 1'b1;
          end else begin
            state_d    = FETCH;
            busy_d     = 1'b1;
            cyc_d      = 1'b1;
            adr_d      = {row_addr[31:2], 2'b00};
            mode_d     = norm_mode(mode_i);
            hs_d       = hscale_i;
            phase_d    = 1'b0;
            src_left_d = hscale_i ? SL_W'(H_PIXELS / 2) : SL_W'(H_PIXELS);
            wr_idx_d   = '0;
          end
        end
      end
      FETCH: begin
        if (wb_ack_i) begin
          cyc_d   = 1'b0;
          u_load  = 1'b1;
          adr_d   = adr_q + 32'd4;
          state_d = UNPACK;
        end else if (wb_err_i) begin
          cyc_d   = 1'b0;
          err_d   = 1'b1;
          state_d = DONE;
        end
      end
      UNPACK: begin
        issue = 1'b1;
        if (!hs_q || phase_q) begin
          u_adv      = 1'b1;
          phase_d    = 1'b0;
          src_left_d = src_left_q - SL_W'(1);
          if (u_last) begin
            if (src_left_q == SL_W'(1)) begin
              state_d = DONE;
            end else begin
              state_d = FETCH;
              cyc_d   = 1'b1;
            end
          end
        end else begin
          phase_d = 1'b1;
        end
      end
      DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (issue && (wr_idx_q < WI_W'(H_PIXELS))) begin
      lb_we_d  = 1'b1;
      lb_adr_d = wr_idx_q[LB_AW-1:0];
      wr_idx_d = wr_idx_q + WI_W'(1);
      dir_d    = u_field;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q    <= IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ovr_q      <= 1'b0;
      err_q      <= 1'b0;
      cyc_q      <= 1'b0;
      adr_q      <= 32'd0;
      mode_q     <= MODE_1BPP;
      hs_q       <= 1'b0;
      phase_q    <= 1'b0;
      src_left_q <= '0;
      wr_idx_q   <= '0;
      lb_we_q    <= 1'b0;
      lb_adr_q   <= '0;
      dir_q      <= 24'd0;
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ovr_q      <= ovr_d;
      err_q      <= err_d;
      cyc_q      <= cyc_d;
      adr_q      <= adr_d;
      mode_q     <= mode_d;
      hs_q       <= hs_d;
      phase_q    <= phase_d;
      src_left_q <= src_left_d;
      wr_idx_q   <= wr_idx_d;
      lb_we_q    <= lb_we_d;
      lb_adr_q   <= lb_adr_d;
      dir_q      <= dir_d;
    end
  end

  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign overrun_o = ovr_q;
  assign err_o     = err_q;
  assign wb_adr_o  = adr_q;
  assign wb_cyc_o  = cyc_q;
  assign wb_stb_o  = cyc_q;
  assign wb_we_o   = 1'b0;
  assign wb_sel_o  = 4'hf;
  assign pal_adr_o = ((state_q == UNPACK) && !dir_mode) ? PAL_AW'(u_field) : '0;
  assign lb_we_o   = lb_we_q;
  assign lb_adr_o  = lb_adr_q;
  // Palette data arrives one cycle after its address, aligned with the registered strobe.
  assign lb_dat_o  = lb_we_q ? (dir_mode ? dir_q : pal_dat_i) : 24'd0;

endmodule

// File: tb/tb_vga_line_fetch.sv
// Directed bench for vga_line_fetch with a Wishbone slave, palette model and write monitor.
module tb_vga_line_fetch;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, line_start, hscale, vscale;
  logic [9:0]  line_num;
  logic [31:0] base;
  logic [15:0] stride;
  logic [2:0]  mode;
  logic        busy_o, done_o, overrun_o, err_o;
  logic [31:0] wb_adr_o, wb_dat_i;
  logic        wb_cyc_o, wb_stb_o, wb_we_o, wb_ack, wb_err;
  logic [3:0]  wb_sel_o;
  logic [7:0]  pal_adr_o;
  logic [23:0] pal_dat;
  logic        lb_we_o;
  logic [9:0]  lb_adr_o;
  logic [23:0] lb_dat_o;

  vga_line_fetch #(.H_PIXELS(640), .Y_W(10), .LB_AW(10), .PAL_AW(8)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .line_start_i(line_start), .line_num_i(line_num),
    .base_i(base), .stride_i(stride), .mode_i(mode), .hscale_i(hscale), .vscale_i(vscale),
    .busy_o(busy_o), .done_o(done_o), .overrun_o(overrun_o), .err_o(err_o),
    .wb_adr_o(wb_adr_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
    .wb_sel_o(wb_sel_o), .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack), .wb_err_i(wb_err),
    .pal_adr_o(pal_adr_o), .pal_dat_i(pal_dat),
    .lb_we_o(lb_we_o), .lb_adr_o(lb_adr_o), .lb_dat_o(lb_dat_o)
  );

  int checks = 0;
  int errors = 0;

  // Stimulus-side settings read by the models
  logic        clr = 1'b0;
  logic [31:0] rd_word = 32'd0;
  logic [31:0] exp_adr = 32'd0;
  logic [2:0]  t_mode = 3'd0;
  logic        t_hs = 1'b0;
  int          ack_delay = 0;
  int          err_idx = -1;

  assign wb_dat_i = rd_word;

  always @(posedge clk) pal_dat <= {16'h5A00, pal_adr_o};

  // Wishbone slave
  int          rd_cnt = 0, rd_adr_bad = 0, wait_cnt = 0;
  logic [31:0] first_adr = 32'd0;
  initial begin wb_ack = 1'b0; wb_err = 1'b0; end
  always @(negedge clk) begin
    if (clr) begin
      rd_cnt = 0; rd_adr_bad = 0; wait_cnt = 0; first_adr = 32'd0;
      wb_ack = 1'b0; wb_err = 1'b0;
    end else if (wb_ack || wb_err) begin
      wb_ack = 1'b0; wb_err = 1'b0;
    end else if (wb_cyc_o && wb_stb_o) begin
      if (wait_cnt >= ack_delay) begin
        if (rd_cnt == 0) first_adr = wb_adr_o;
        if (wb_adr_o !== exp_adr + 32'(4 * rd_cnt)) rd_adr_bad++;
        if (rd_cnt == err_idx) wb_err = 1'b1; else wb_ack = 1'b1;
        rd_cnt++;
        wait_cnt = 0;
      end else begin
        wait_cnt++;
      end
    end else begin
      wait_cnt = 0;
    end
  end

  function automatic logic [23:0] exp_pix(input int i);
    int bpp, ppw, src, pos;
    logic [31:0] f;
    if (t_mode == 3'd4) return rd_word[23:0];
    bpp = 1 << t_mode;
    ppw = 32 / bpp;
    src = t_hs ? i / 2 : i;
    pos = src % ppw;
    f = (rd_word >> (32 - bpp * (pos + 1))) & ((32'd1 << bpp) - 32'd1);
    return {16'h5A00, f[7:0]};
  endfunction

  // Line buffer write monitor
  int          wr_cnt = 0, wr_adr_bad = 0, wr_dat_bad = 0, done_cnt = 0;
  logic [23:0] wr_dat [0:639];
  always @(negedge clk) begin
    if (clr) begin
      wr_cnt = 0; wr_adr_bad = 0; wr_dat_bad = 0; done_cnt = 0;
    end else begin
      if (lb_we_o) begin
        if (lb_adr_o !== 10'(wr_cnt)) wr_adr_bad++;
        if (lb_dat_o !== exp_pix(wr_cnt)) wr_dat_bad++;
        if (wr_cnt < 640) wr_dat[wr_cnt] = lb_dat_o;
        wr_cnt++;
      end
      if (done_o) done_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic start_line(input logic [2:0] m, input logic hs, input logic vs,
                            input logic [9:0] ln, input logic [31:0] b, input logic [15:0] s);
    @(posedge clk); #1 clr = 1'b1; t_mode = m; t_hs = hs;
    @(negedge clk); #1 clr = 1'b0;
    @(posedge clk); #1;
    mode = m; hscale = hs; vscale = vs; line_num = ln; base = b; stride = s;
    line_start = 1'b1;
    @(posedge clk); #1 line_start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (done_o !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(n < budget), 32'd1);
  endtask

  initial begin
    int n;
    rst_n = 1'b0; line_start = 1'b0; hscale = 1'b0; vscale = 1'b0;
    line_num = 10'd0; base = 32'd0; stride = 16'd0; mode = 3'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_ovr", 32'(overrun_o), 32'd0);
    chk("rst_err", 32'(err_o), 32'd0);
    chk("rst_cyc", 32'({wb_cyc_o, wb_stb_o, wb_we_o}), 32'd0);
    chk("rst_sel", 32'(wb_sel_o), 32'hf);
    chk("rst_lb", 32'({lb_we_o, lb_adr_o}), 32'd0);
    chk("rst_lbdat", 32'(lb_dat_o), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // 8bpp, 2x both ways, line 5 -> row 2
    rd_word = 32'h01020304; exp_adr = 32'hC000_0280; ack_delay = 0; err_idx = -1;
    start_line(3'd3, 1'b1, 1'b1, 10'd5, 32'hC000_0000, 16'd320);
    chk("t1_busy", 32'(busy_o), 32'd1);
    wait_done("t1_timeout", 10000);
    repeat (4) @(negedge clk);
    chk("t1_reads", rd_cnt, 32'd80);
    chk("t1_first_adr", first_adr, 32'hC000_0280);
    chk("t1_adr_seq", rd_adr_bad, 32'd0);
    chk("t1_writes", wr_cnt, 32'd640);
    chk("t1_lb_adr", wr_adr_bad, 32'd0);
    chk("t1_lb_dat", wr_dat_bad, 32'd0);
    chk("t1_pix0", 32'(wr_dat[0]), 32'h5A0001);
    chk("t1_pix1", 32'(wr_dat[1]), 32'h5A0001);
    chk("t1_pix2", 32'(wr_dat[2]), 32'h5A0002);
    chk("t1_pix7", 32'(wr_dat[7]), 32'h5A0004);
    chk("t1_pix639", 32'(wr_dat[639]), 32'h5A0004);
    chk("t1_done_once", done_cnt, 32'd1);
    chk("t1_idle", 32'(busy_o), 32'd0);

    // 1bpp, no scaling: row 3 at stride 80
    rd_word = 32'h80000001; exp_adr = 32'h0000_10F0;
    start_line(3'd0, 1'b0, 1'b0, 10'd3, 32'h0000_1000, 16'd80);
    wait_done("t2_timeout", 10000);
    repeat (4) @(negedge clk);
    chk("t2_reads", rd_cnt, 32'd20);
    chk("t2_adr_seq", rd_adr_bad, 32'd0);
    chk("t2_writes", wr_cnt, 32'd640);
    chk("t2_lb_dat", wr_dat_bad, 32'd0);
    chk("t2_pix0", 32'(wr_dat[0]), 32'h5A0001);
    chk("t2_pix1", 32'(wr_dat[1]), 32'h5A0000);
    chk("t2_pix30", 32'(wr_dat[30]), 32'h5A0000);
    chk("t2_pix31", 32'(wr_dat[31]), 32'h5A0001);
    chk("t2_pix32", 32'(wr_dat[32]), 32'h5A0001);
    chk("t2_done_once", done_cnt, 32'd1);

    // Direct 24bpp, row address wraps past 2^32
    rd_word = 32'hFF123456; exp_adr = 32'h0000_0100;
    start_line(3'd4, 1'b0, 1'b0, 10'd1, 32'hFFFF_FF00, 16'h0200);
    wait_done("t3_timeout", 20000);
    repeat (4) @(negedge clk);
    chk("t3_reads", rd_cnt, 32'd640);
    chk("t3_first_adr", first_adr, 32'h0000_0100);
    chk("t3_adr_seq", rd_adr_bad, 32'd0);
    chk("t3_writes", wr_cnt, 32'd640);
    chk("t3_pix0", 32'(wr_dat[0]), 32'h123456);
    chk("t3_pix639", 32'(wr_dat[639]), 32'h123456);
    chk("t3_lb_dat", wr_dat_bad, 32'd0);

    // 4bpp with slow acks
    rd_word = 32'h89ABCDEF; exp_adr = 32'h0000_4080; ack_delay = 7;
    start_line(3'd2, 1'b0, 1'b1, 10'd4, 32'h0000_4000, 16'h0040);
    wait_done("t4_timeout", 20000);
    repeat (4) @(negedge clk);
    chk("t4_reads", rd_cnt, 32'd80);
    chk("t4_writes", wr_cnt, 32'd640);
    chk("t4_lb_adr", wr_adr_bad, 32'd0);
    chk("t4_lb_dat", wr_dat_bad, 32'd0);
    chk("t4_pix0", 32'(wr_dat[0]), 32'h5A0008);
    chk("t4_pix7", 32'(wr_dat[7]), 32'h5A000F);
    chk("t4_done_once", done_cnt, 32'd1);

    // Bus error on the fourth read
    rd_word = 32'h01020304; exp_adr = 32'h0000_2000; ack_delay = 0; err_idx = 3;
    start_line(3'd3, 1'b0, 1'b0, 10'd0, 32'h0000_2000, 16'd0);
    wait_done("t5_timeout", 2000);
    repeat (4) @(negedge clk);
    chk("t5_reads", rd_cnt, 32'd4);
    chk("t5_err", 32'(err_o), 32'd1);
    chk("t5_done_once", done_cnt, 32'd1);
    chk("t5_busy", 32'(busy_o), 32'd0);
    chk("t5_writes", wr_cnt, 32'd12);
    chk("t5_lb_adr", wr_adr_bad, 32'd0);

    // Overrun mid-line, then reset during a fetch
    err_idx = -1; ack_delay = 5; exp_adr = 32'h0000_3000;
    start_line(3'd3, 1'b1, 1'b0, 10'd0, 32'h0000_3000, 16'd0);
    repeat (30) @(posedge clk);
    #1 line_start = 1'b1;
    @(posedge clk); #1 line_start = 1'b0;
    @(negedge clk);
    chk("t6_ovr", 32'(overrun_o), 32'd1);
    chk("t6_busy", 32'(busy_o), 32'd1);
    chk("t6_err_sticky", 32'(err_o), 32'd1);
    n = 0;
    while (!wb_cyc_o && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("t6_cyc_seen", 32'(wb_cyc_o), 32'd1);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("t6_rst_cyc", 32'(wb_cyc_o), 32'd0);
    chk("t6_rst_busy", 32'(busy_o), 32'd0);
    chk("t6_rst_ovr", 32'(overrun_o), 32'd0);
    chk("t6_rst_err", 32'(err_o), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // line_start coinciding with done_o is dropped and flagged
    ack_delay = 0; rd_word = 32'h80000001; exp_adr = 32'h0000_5000;
    start_line(3'd0, 1'b0, 1'b0, 10'd0, 32'h0000_5000, 16'd0);
    chk("t7_ovr_clear", 32'(overrun_o), 32'd0);
    wait_done("t7_timeout", 5000);
    line_start = 1'b1;
    @(posedge clk); #1 line_start = 1'b0;
    @(negedge clk);
    chk("t7_ovr", 32'(overrun_o), 32'd1);
    chk("t7_busy", 32'(busy_o), 32'd0);
    repeat (3) @(negedge clk);
    chk("t7_no_fetch", 32'({wb_cyc_o, busy_o}), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
